// File: rtl/poly_pkg.sv
// Shared MIDI constants, parser state encoding and elaboration helpers
// for poly_voice_alloc and its voice_lru sub-module.
package poly_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [3:0] CC           = 4'hB;
  localparam logic [3:0] PROG         = 4'hC;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam logic [6:0] CC_SUSTAIN   = 7'd64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_VEL,
    S_PROG,
    S_CC_NUM,
    S_CC_VAL,
    S_SKIP
  } parse_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/poly_voice_alloc_voice_lru.sv
// Least-recently-triggered tracker: rank 0 = newest, rank VOICES-1 = oldest.
// Ranks stay a permutation of 0..VOICES-1 across every touch.
module voice_lru
  import poly_pkg::*;
#(
  parameter  int unsigned VOICES = 4,
  localparam int unsigned IW     = clog2(VOICES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_touch,
  input  logic [IW-1:0] i_idx,
  output logic [IW-1:0] o_oldest
);

  logic [IW-1:0] r_rank [VOICES];
  logic [IW-1:0] w_old;

  always_comb begin
    w_old    = '0;
    o_oldest = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      if (IW'(i) == i_idx) w_old = r_rank[i];
      if (r_rank[i] == IW'(VOICES - 1)) o_oldest = IW'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < VOICES; i++) r_rank[i] <= IW'(i);
    end else if (i_touch) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        if (IW'(i) == i_idx)      r_rank[i] <= '0;
        else if (r_rank[i] < w_old) r_rank[i] <= r_rank[i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/poly_voice_alloc.sv
// Single-channel MIDI parser with VOICES-way note allocation (retrigger,
// lowest free, else steal oldest). Optional sustain pedal: POLY_SUSTAIN_PEDAL_EN.
module poly_voice_alloc
  import poly_pkg::*;
#(
  parameter int unsigned VOICES = 4,
  parameter int unsigned VEL_W  = 7
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      CE,
  input  logic [3:0]                CHANNEL,
  input  logic [7:0]                DATA,
  input  logic                      DV,
  output logic [6:0]                PROGRAM,
  output logic [VOICES*7-1:0]       NOTE_NUM,
  output logic [VOICES*VEL_W-1:0]   NOTE_VEL,
  output logic [VOICES-1:0]         VOICE_ACTIVE,
  output logic [VOICES-1:0]         VOICE_TRIG
);

  localparam int unsigned IW = clog2(VOICES);

  parse_state_e     r_state, w_state_nx;
  logic [6:0]       r_key, r_prog;
  logic             r_off_status;
  logic [6:0]       r_note [VOICES];
  logic [VEL_W-1:0] r_vel  [VOICES];
  logic [VOICES-1:0] r_active, r_trig;
  logic             w_status, w_data, w_note_ev, w_on, w_off, w_hit, w_free;
  logic [IW-1:0]    w_hit_idx, w_free_idx, w_oldest, w_sel;
  logic [VEL_W-1:0] w_vel;
`ifdef POLY_SUSTAIN_PEDAL_EN
  logic [6:0]        r_cc_num;
  logic              r_sustain, w_cc_ev, w_sus_fall;
  logic [VOICES-1:0] r_sus;
`endif

  // Realtime bytes are neither status nor data, so they leave the parser untouched.
  assign w_status = CE & DV & DATA[7] & (DATA < REALTIME_MIN);
  assign w_data   = CE & DV & ~DATA[7];

  always_comb begin
    w_state_nx = r_state;
    w_note_ev  = 1'b0;
`ifdef POLY_SUSTAIN_PEDAL_EN
    w_cc_ev    = 1'b0;
`endif
    if (w_status) begin
      if (DATA[7:4] == 4'hF)          w_state_nx = S_IDLE;
      else if (DATA[3:0] != CHANNEL)  w_state_nx = S_SKIP;
      else begin
        case (DATA[7:4])
          NOTE_OFF, NOTE_ON: w_state_nx = S_KEY;
          PROG:              w_state_nx = S_PROG;
`ifdef POLY_SUSTAIN_PEDAL_EN
          CC:                w_state_nx = S_CC_NUM;
`endif
          default:           w_state_nx = S_SKIP;
        endcase
      end
    end else if (w_data) begin
      case (r_state)
        S_KEY: w_state_nx = S_VEL;
        S_VEL: begin
          w_state_nx = S_KEY;
          w_note_ev  = 1'b1;
        end
`ifdef POLY_SUSTAIN_PEDAL_EN
        S_CC_NUM: w_state_nx = S_CC_VAL;
        S_CC_VAL: begin
          w_state_nx = S_CC_NUM;
          w_cc_ev    = 1'b1;
        end
`endif
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_key        <= '0;
      r_prog       <= '0;
      r_off_status <= 1'b0;
`ifdef POLY_SUSTAIN_PEDAL_EN
      r_cc_num     <= '0;
      r_sustain    <= 1'b0;
`endif
    end else begin
      if (w_status) r_off_status <= (DATA[7:4] == NOTE_OFF);
      if (w_data && r_state == S_KEY)  r_key  <= DATA[6:0];
      if (w_data && r_state == S_PROG) r_prog <= DATA[6:0];
`ifdef POLY_SUSTAIN_PEDAL_EN
      if (w_data && r_state == S_CC_NUM) r_cc_num <= DATA[6:0];
      if (w_cc_ev && r_cc_num == CC_SUSTAIN) r_sustain <= DATA[6];
`endif
    end
  end

`ifdef POLY_SUSTAIN_PEDAL_EN
  assign w_sus_fall = w_cc_ev & (r_cc_num == CC_SUSTAIN) & r_sustain & ~DATA[6];
`endif

  assign w_vel = VEL_W'(DATA[6:0]);
  assign w_on  = w_note_ev & ~r_off_status & (DATA[6:0] != 7'd0);
  assign w_off = w_note_ev & ~w_on;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = VOICES; i > 0; i--) begin
      if (r_active[i-1] && r_note[i-1] == r_key) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i - 1);
      end
      if (!r_active[i-1]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i - 1);
      end
    end
    w_sel = w_hit ? w_hit_idx : (w_free ? w_free_idx : w_oldest);
  end

  voice_lru #(.VOICES(VOICES)) u_lru (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_touch  (w_on),
    .i_idx    (w_sel),
    .o_oldest (w_oldest)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
      end
      r_active <= '0;
      r_trig   <= '0;
`ifdef POLY_SUSTAIN_PEDAL_EN
      r_sus    <= '0;
`endif
    end else begin
      r_trig <= '0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        if (w_on && IW'(i) == w_sel) begin
          r_note[i]   <= r_key;
          r_vel[i]    <= w_vel;
          r_active[i] <= 1'b1;
          r_trig[i]   <= 1'b1;
`ifdef POLY_SUSTAIN_PEDAL_EN
          r_sus[i]    <= 1'b0;
`endif
        end else if (w_off && r_active[i] && r_note[i] == r_key) begin
`ifdef POLY_SUSTAIN_PEDAL_EN
          if (r_sustain) r_sus[i] <= 1'b1;
          else begin
            r_active[i] <= 1'b0;
            r_vel[i]    <= '0;
          end
        end else if (w_sus_fall && r_sus[i]) begin
          r_active[i] <= 1'b0;
          r_vel[i]    <= '0;
          r_sus[i]    <= 1'b0;
`else
          r_active[i] <= 1'b0;
          r_vel[i]    <= '0;
`endif
        end
      end
    end
  end

  always_comb begin
    NOTE_NUM = '0;
    NOTE_VEL = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      NOTE_NUM[7*i +: 7]         = r_note[i];
      NOTE_VEL[VEL_W*i +: VEL_W] = r_vel[i];
    end
  end

  assign PROGRAM      = r_prog;
  assign VOICE_ACTIVE = r_active;
  assign VOICE_TRIG   = r_trig;

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Scoreboard bench for poly_voice_alloc (4 voices, 7-bit velocity).
`timescale 1ns/1ps
module tb_poly_voice_alloc;

  localparam int unsigned VOICES = 4;
  localparam int unsigned VEL_W  = 7;
`ifdef POLY_SUSTAIN_PEDAL_EN
  localparam bit SUS = 1'b1;
`else
  localparam bit SUS = 1'b0;
`endif

  logic                    CLK = 1'b0;
  logic                    RST_N = 1'b0;
  logic                    CE = 1'b1;
  logic [3:0]              CHANNEL = 4'h0;
  logic [7:0]              DATA = 8'h00;
  logic                    DV = 1'b0;
  logic [6:0]              PROGRAM;
  logic [VOICES*7-1:0]     NOTE_NUM;
  logic [VOICES*VEL_W-1:0] NOTE_VEL;
  logic [VOICES-1:0]       VOICE_ACTIVE;
  logic [VOICES-1:0]       VOICE_TRIG;

  poly_voice_alloc #(.VOICES(VOICES), .VEL_W(VEL_W)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CE           (CE),
    .CHANNEL      (CHANNEL),
    .DATA         (DATA),
    .DV           (DV),
    .PROGRAM      (PROGRAM),
    .NOTE_NUM     (NOTE_NUM),
    .NOTE_VEL     (NOTE_VEL),
    .VOICE_ACTIVE (VOICE_ACTIVE),
    .VOICE_TRIG   (VOICE_TRIG)
  );

  always #5 CLK = ~CLK;

  // bytes are left-aligned: first byte in [23:16]
  typedef struct {
    string       name;
    logic [23:0] bytes;
    int          nb;
    logic        ce;
    int          v;
    logic [28:0] val;
  } step_t;

  step_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic step_t st(input string n, input logic [23:0] b, input int nb,
                               input int v, input logic [3:0] act, input logic [3:0] trig,
                               input logic [6:0] note, input logic [6:0] vel,
                               input logic [6:0] prog, input logic ce = 1'b1);
    step_t s;
    s.name = n; s.bytes = b; s.nb = nb; s.ce = ce; s.v = v;
    s.val = {act, trig, note, vel, prog};
    return s;
  endfunction

  function automatic logic [28:0] obs(input int v);
    return {VOICE_ACTIVE, VOICE_TRIG, NOTE_NUM[7*v +: 7], NOTE_VEL[7*v +: 7], PROGRAM};
  endfunction

  task automatic do_reset();
    RST_N = 1'b0; DV = 1'b0; CE = 1'b1; CHANNEL = 4'h0; DATA = 8'h00;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Returns at the falling edge after the last byte was taken, i.e. t+1.
  task automatic drive(input step_t s);
    CE = s.ce;
    for (int k = 0; k < s.nb; k++) begin
      @(negedge CLK);
      DATA = s.bytes[23-8*k -: 8];
      DV   = 1'b1;
      @(negedge CLK);
      DV   = 1'b0;
    end
    if (s.nb == 0) @(negedge CLK);
    CE = 1'b1;
  endtask

  task automatic test_reset();
    step_t e;
    do_reset();
    n_checks++;
    if (obs(0) !== 29'd0) begin
      n_errors++; $display("FAIL reset_state: got %h expected %h", obs(0), 29'd0);
    end
    n_checks++;
    if (NOTE_NUM !== '0 || NOTE_VEL !== '0) begin
      n_errors++; $display("FAIL reset_buses: got num=%h vel=%h expected 0", NOTE_NUM, NOTE_VEL);
    end
    drive(st("partial", 24'h903C00, 2, 0, 4'b0, 4'b0, 7'h0, 7'h0, 7'h0));
    do_reset();
    sb.push_back(st("reset_mid_msg", 24'h640000, 1, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h00));
    drive(sb[sb.size()-1]);
    e = sb.pop_front();
    n_checks++;
    if (obs(e.v) !== e.val) begin
      n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs(e.v), e.val);
    end
  endtask

  task automatic test_note_on();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(st("on_first",  24'h903C64, 3, 0, 4'b0001, 4'b0001, 7'h3C, 7'h64, 7'h00));
    t.push_back(st("on_trig_0", 24'h000000, 0, 0, 4'b0001, 4'b0000, 7'h3C, 7'h64, 7'h00));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs(e.v) !== e.val) begin
        n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs(e.v), e.val);
      end
    end
  endtask

  task automatic test_running_status();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(st("rs_v0",  24'h903C64, 3, 0, 4'b0001, 4'b0001, 7'h3C, 7'h64, 7'h00));
    t.push_back(st("rs_v1",  24'h405000, 2, 1, 4'b0011, 4'b0010, 7'h40, 7'h50, 7'h00));
    t.push_back(st("rs_v2",  24'h433000, 2, 2, 4'b0111, 4'b0100, 7'h43, 7'h30, 7'h00));
    t.push_back(st("rs_off", 24'h804000, 3, 1, 4'b0101, 4'b0000, 7'h40, 7'h00, 7'h00));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs(e.v) !== e.val) begin
        n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs(e.v), e.val);
      end
    end
  endtask

  task automatic test_steal();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(st("st_v0",    24'h903C64, 3, 0, 4'b0001, 4'b0001, 7'h3C, 7'h64, 7'h00));
    t.push_back(st("st_v1",    24'h3E6400, 2, 1, 4'b0011, 4'b0010, 7'h3E, 7'h64, 7'h00));
    t.push_back(st("st_v2",    24'h406400, 2, 2, 4'b0111, 4'b0100, 7'h40, 7'h64, 7'h00));
    t.push_back(st("st_v3",    24'h416400, 2, 3, 4'b1111, 4'b1000, 7'h41, 7'h64, 7'h00));
    t.push_back(st("steal_v0", 24'h436400, 2, 0, 4'b1111, 4'b0001, 7'h43, 7'h64, 7'h00));
    t.push_back(st("steal_v1", 24'h456400, 2, 1, 4'b1111, 4'b0010, 7'h45, 7'h64, 7'h00));
    t.push_back(st("retrig",   24'h417F00, 2, 3, 4'b1111, 4'b1000, 7'h41, 7'h7F, 7'h00));
    t.push_back(st("steal_v2", 24'h476400, 2, 2, 4'b1111, 4'b0100, 7'h47, 7'h64, 7'h00));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs(e.v) !== e.val) begin
        n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs(e.v), e.val);
      end
    end
  endtask

  task automatic test_channel_realtime();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(st("other_chan", 24'h913C64, 3, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h00));
    t.push_back(st("rt_mid",     24'h903CF8, 3, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h00));
    t.push_back(st("rt_after",   24'h640000, 1, 0, 4'b0001, 4'b0001, 7'h3C, 7'h64, 7'h00));
    t.push_back(st("vel0_off",   24'h903C00, 3, 0, 4'b0000, 4'b0000, 7'h3C, 7'h00, 7'h00));
    t.push_back(st("unheld_off", 24'h805000, 3, 0, 4'b0000, 4'b0000, 7'h3C, 7'h00, 7'h00));
    t.push_back(st("reuse_v0",   24'h903E64, 3, 0, 4'b0001, 4'b0001, 7'h3E, 7'h64, 7'h00));
    t.push_back(st("sysex_idle", 24'hF03C7F, 3, 0, 4'b0001, 4'b0000, 7'h3E, 7'h64, 7'h00));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs(e.v) !== e.val) begin
        n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs(e.v), e.val);
      end
    end
  endtask

  task automatic test_program();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(st("prog_5",     24'hC00500, 2, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h05));
    t.push_back(st("prog_run_7", 24'h070000, 1, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h07));
    t.push_back(st("prog_ce0",   24'hC00900, 2, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h07, 1'b0));
    t.push_back(st("prog_held",  24'h0A0000, 1, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h0A));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs(e.v) !== e.val) begin
        n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs(e.v), e.val);
      end
    end
  endtask

  task automatic test_sustain();
    step_t t[$];
    step_t e;
    do_reset();
    t.push_back(st("sus_on",  24'hB0407F, 3, 0, 4'b0000, 4'b0000, 7'h00, 7'h00, 7'h00));
    t.push_back(st("sus_key", 24'h903C64, 3, 0, 4'b0001, 4'b0001, 7'h3C, 7'h64, 7'h00));
    t.push_back(st("sus_off", 24'h803C00, 3, 0, SUS ? 4'b0001 : 4'b0000, 4'b0000, 7'h3C,
                   SUS ? 7'h64 : 7'h00, 7'h00));
    t.push_back(st("sus_rel", 24'hB04000, 3, 0, 4'b0000, 4'b0000, 7'h3C, 7'h00, 7'h00));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs(e.v) !== e.val) begin
        n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs(e.v), e.val);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_steal();
    test_channel_realtime();
    test_program();
    test_sustain();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/poly_voice_alloc.md
Name: poly_voice_alloc

Overview:
- Parametrised successor to the fixed 4-voice MIDI interpreter.
- Parses the UART MIDI byte stream for one channel and allocates note-on events across VOICES voices:
  - retrigger if the note is already held;
  - otherwise lowest free voice;
  - otherwise steal the least-recently-triggered voice.
- Sits between uart_rx and nco_bank and drives flat per-voice note/velocity buses.

Parameters:
- VOICES, 4, number of voices (2..16).
- VEL_W, 7, velocity width; MIDI 7-bit value, zero-extended if VEL_W>7.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; when low, DV ignored and all state held
- CHANNEL  in  4  MIDI channel to accept
- DATA  in  8  received byte
- DV  in  1  DATA valid, single-cycle pulse
- PROGRAM  out  7  last program-change value
- NOTE_NUM  out  VOICES*7  voice i at [7i+6:7i]
- NOTE_VEL  out  VOICES*VEL_W  voice i velocity; 0 = released
- VOICE_ACTIVE  out  VOICES  voice holds a note
- VOICE_TRIG  out  VOICES  one-cycle pulse when voice (re)assigned

Behaviour:
- Reset (async assert, sync deassert inside): PROGRAM=0, NOTE_NUM=0, NOTE_VEL=0, VOICE_ACTIVE=0, VOICE_TRIG=0, LRU rank[i]=i, parser IDLE. Reset mid-message discards the partial message.
- Byte accepted only when CE&&DV.
- Realtime bytes 0xF8-0xFF: ignored entirely, parser state untouched.
- Status byte (bit7=1, <0xF8):
  - 0xF0-0xF7: clear running status, go IDLE.
  - Channel != CHANNEL: SKIP.
  - 0x8n/0x9n: KEY.
  - 0xCn: PROG.
  - 0xBn: CC_NUM (macro on) or SKIP.
  - All other channel messages: SKIP.
- Data bytes:
  - IDLE/SKIP: ignored.
  - KEY: latch key, go VEL.
  - VEL: commit note event, return to KEY (running status).
  - PROG: PROGRAM<=data, stay PROG.
- Note event, last byte at cycle t; outputs registered and visible at t+1.
- Note-off = 0x8n or 0x9n with vel 0:
  - Every active voice with NOTE_NUM==key: VOICE_ACTIVE<=0, NOTE_VEL<=0, NOTE_NUM retained.
  - Unheld key: no change.
- Note-on, selection priority:
  - (a) active voice with same key;
  - (b) lowest-index inactive voice;
  - (c) voice with rank VOICES-1 (oldest).
- Note-on, chosen voice: NOTE_NUM<=key, NOTE_VEL<=vel, VOICE_ACTIVE<=1, VOICE_TRIG bit pulses at t+1 only.
- LRU update on note-on: old=rank[chosen]; rank[chosen]<=0; every voice with rank<old increments. Ranks always form a permutation of 0..VOICES-1. Note-off does not change ranks.
- Only one event can commit per cycle (one byte per DV), so no simultaneous on/off.

Optional Feature:
- Macro POLY_SUSTAIN_PEDAL_EN.
- Defined:
  - CC 64 parsed (CC_NUM→CC_VAL→CC_NUM running status); sustain<=(val>=64).
  - Note-off while sustain: voice marked sustained; stays active, velocity kept.
  - Sustain falling: all sustained voices released (ACTIVE=0, VEL=0) at next cycle.
  - Note-on to a sustained voice's key retriggers it and clears the mark.
  - Sustained voices count as active for allocation.
- Undefined: 0xBn goes to SKIP; no sustain state exists.

Decomposition:
- Package poly_pkg:
  - MIDI status constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB, PROG=4'hC, REALTIME_MIN=8'hF8, CC_SUSTAIN=7'd64);
  - parser state enum (IDLE, KEY, VEL, PROG, CC_NUM, CC_VAL, SKIP);
  - clog2 function.
- Sub-module voice_lru: rank registers, touch(index) update, oldest-index output.

Test Plan:
- Reset; 0x90 0x3C 0x64 → t+1: NOTE_NUM[0]=0x3C, NOTE_VEL[0]=0x64, ACTIVE=0001, TRIG=0001 for one cycle.
- 0x90 3C 64, 40 50, 43 30 (running status), then 0x80 40 00 → voices 0/1/2 allocated; then ACTIVE=0101, NOTE_VEL[1]=0, NOTE_NUM[1]=0x40.
- 0x90 then keys 3C,3E,40,41 (vel 0x64) then 43 → fifth steals voice0: ACTIVE=1111, TRIG=0001, NOTE_NUM[0]=0x43; then 0x45 steals voice1.
- CHANNEL=0: 0x91 3C 64 → no change; 0x90 3C F8 64 → voice0 allocated, 0xF8 ignored; 0x90 3C 00 → voice0 released.
- 0xC0 05 → PROGRAM=5 at t+1; 0x07 (running) → PROGRAM=7; CE=0 during 0xC0 09 → PROGRAM stays 7.
- Macro on: B0 40 7F; 90 3C 64; 80 3C 00 → ACTIVE stays 0001; B0 40 00 → ACTIVE=0000, VEL=0. Macro off: release occurs at note-off.
